// File: rtl/auth_cfg_pkg.sv
// Shared constants and address-map helpers for the authentication key register file.
// Region offsets are byte offsets inside one channel's 0x100 window.
package auth_cfg_pkg;

  localparam int CH_STRIDE  = 'h100;
  localparam int STATUS_OFS = 'hF8;
  localparam int WORD_B     = 8;

  localparam int STS_PEND  = 0;
  localparam int STS_BUSY  = 1;
  localparam int STS_VALID = 2;

  function automatic int n_words(input int bits, input int dw);
    return (bits + dw - 1) / dw;
  endfunction

  function automatic int poly_ofs();
    return 0;
  endfunction

  function automatic int toep_ofs(input int pw);
    return pw * WORD_B;
  endfunction

  function automatic int otp_ofs(input int pw, input int tw);
    return (pw + tw) * WORD_B;
  endfunction

endpackage

// File: rtl/auth_key_regfile_if.sv
// Host config port: AXI-lite-style write address/data and read address/data channels.
interface auth_key_regfile_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata,
    output arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata,
    input  arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/auth_key_regfile_bank.sv
// One channel's shadow/active key registers, word write decode and commit copy.
// AUTH_KEY_READBACK_EN adds a shadow read port selected by word index.
module auth_key_bank
  import auth_cfg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int POLY_W = 186,
  parameter int TOEP_W = 231,
  parameter int OTP_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [4:0]        i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_copy,
`ifdef AUTH_KEY_READBACK_EN
  input  logic [4:0]        i_ridx,
  output logic [DATA_W-1:0] o_rdata,
`endif
  output logic [POLY_W-1:0] o_poly,
  output logic [TOEP_W-1:0] o_toep,
  output logic [OTP_W-1:0]  o_otp
);

  localparam int PW  = n_words(POLY_W, DATA_W);
  localparam int TW  = n_words(TOEP_W, DATA_W);
  localparam int OW  = n_words(OTP_W, DATA_W);
  localparam int PB  = poly_ofs() / WORD_B;
  localparam int TB  = toep_ofs(PW) / WORD_B;
  localparam int OB  = otp_ofs(PW, TW) / WORD_B;
  localparam int TOT = PW + TW + OW;

  logic [POLY_W-1:0] r_poly_sh, r_poly, w_poly_nx;
  logic [TOEP_W-1:0] r_toep_sh, r_toep, w_toep_nx;
  logic [OTP_W-1:0]  r_otp_sh, r_otp, w_otp_nx;

`ifdef AUTH_KEY_READBACK_EN
  logic [DATA_W-1:0] w_racc [TOT+1];
  assign w_racc[0] = '0;
  assign o_rdata   = w_racc[TOT];
`endif

  // Top words are narrower than DATA_W; excess write bits are never stored
  for (genvar k = 0; k < PW; k++) begin : g_pw
    localparam int LO = k * DATA_W;
    localparam int WD = (POLY_W - LO < DATA_W) ? POLY_W - LO : DATA_W;
    logic w_hit;
    assign w_hit = i_we && (i_idx == 5'(PB + k));
    assign w_poly_nx[LO+:WD] = w_hit ? i_wdata[WD-1:0] : r_poly_sh[LO+:WD];
`ifdef AUTH_KEY_READBACK_EN
    assign w_racc[PB+k+1] = w_racc[PB+k] |
      ((i_ridx == 5'(PB + k)) ? DATA_W'(r_poly_sh[LO+:WD]) : '0);
`endif
  end

  for (genvar k = 0; k < TW; k++) begin : g_tw
    localparam int LO = k * DATA_W;
    localparam int WD = (TOEP_W - LO < DATA_W) ? TOEP_W - LO : DATA_W;
    logic w_hit;
    assign w_hit = i_we && (i_idx == 5'(TB + k));
    assign w_toep_nx[LO+:WD] = w_hit ? i_wdata[WD-1:0] : r_toep_sh[LO+:WD];
`ifdef AUTH_KEY_READBACK_EN
    assign w_racc[TB+k+1] = w_racc[TB+k] |
      ((i_ridx == 5'(TB + k)) ? DATA_W'(r_toep_sh[LO+:WD]) : '0);
`endif
  end

  for (genvar k = 0; k < OW; k++) begin : g_ow
    localparam int LO = k * DATA_W;
    localparam int WD = (OTP_W - LO < DATA_W) ? OTP_W - LO : DATA_W;
    logic w_hit;
    assign w_hit = i_we && (i_idx == 5'(OB + k));
    assign w_otp_nx[LO+:WD] = w_hit ? i_wdata[WD-1:0] : r_otp_sh[LO+:WD];
`ifdef AUTH_KEY_READBACK_EN
    assign w_racc[OB+k+1] = w_racc[OB+k] |
      ((i_ridx == 5'(OB + k)) ? DATA_W'(r_otp_sh[LO+:WD]) : '0);
`endif
  end

  // Copy samples the pre-write shadow, so a same-cycle write waits for the next commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poly_sh <= '0;
      r_toep_sh <= '0;
      r_otp_sh  <= '0;
      r_poly    <= '0;
      r_toep    <= '0;
      r_otp     <= '0;
    end else begin
      r_poly_sh <= w_poly_nx;
      r_toep_sh <= w_toep_nx;
      r_otp_sh  <= w_otp_nx;
      if (i_copy) begin
        r_poly <= r_poly_sh;
        r_toep <= r_toep_sh;
        r_otp  <= r_otp_sh;
      end
    end
  end

  assign o_poly = r_poly;
  assign o_toep = r_toep;
  assign o_otp  = r_otp;

endmodule

// File: rtl/auth_key_regfile.sv
// Multi-channel shadow/active key register file with host config port and deferred commit.
// Define AUTH_KEY_READBACK_EN to make key offsets readable; otherwise only STATUS reads back.
module auth_key_regfile
  import auth_cfg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int POLY_W = 186,
  parameter int TOEP_W = 231,
  parameter int OTP_W  = 40,
  parameter int NUM_CH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  auth_key_regfile_if.slave        bus,
  input  logic                     commit,
  input  logic                     busy,
  output logic [NUM_CH*POLY_W-1:0] poly_key,
  output logic [NUM_CH*TOEP_W-1:0] toep_key,
  output logic [NUM_CH*OTP_W-1:0]  otp_key,
  output logic                     key_valid
);

  localparam int         CH_SH   = $clog2(CH_STRIDE);
  localparam int         CW      = ADDR_W - CH_SH;
  localparam logic [4:0] STS_IDX = 5'(STATUS_OFS / WORD_B);

  logic              r_aw_held, r_w_held, r_clr;
  logic [ADDR_W-1:3] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_exec;
  logic [ADDR_W-1:3] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [CW-1:0]     w_wch;
  logic [4:0]        w_widx;
  logic              r_pend, r_valid, w_copy;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata, w_sts, w_rnext, w_rkey;
  logic              w_ar_hs, w_rsel_sts;
  logic [CW-1:0]     w_rch;
  logic [4:0]        w_ridx;
  logic              w_unused;

  assign w_unused = ^{bus.awaddr[2:0], bus.araddr[2:0]};

  assign bus.awready = ~r_aw_held;
  assign bus.wready  = ~r_w_held;

  // r_clr blocks re-execution while both holds drain after a write
  assign w_exec  = (r_aw_held | bus.awvalid) & (r_w_held | bus.wvalid) & ~r_clr;
  assign w_waddr = r_aw_held ? r_awaddr : bus.awaddr[ADDR_W-1:3];
  assign w_wdata = r_w_held ? r_wdata : bus.wdata;
  assign w_wch   = w_waddr[ADDR_W-1:CH_SH];
  assign w_widx  = w_waddr[CH_SH-1:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_clr     <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
    end else begin
      r_clr <= w_exec;
      if (r_clr) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (bus.awvalid && !r_aw_held) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= bus.awaddr[ADDR_W-1:3];
        end
        if (bus.wvalid && !r_w_held) begin
          r_w_held <= 1'b1;
          r_wdata  <= bus.wdata;
        end
      end
    end
  end

  assign w_copy = (commit | r_pend) & ~busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_pend  <= busy & (commit | r_pend);
      r_valid <= r_valid | w_copy;
    end
  end

  assign key_valid = r_valid;

  assign w_rch  = bus.araddr[ADDR_W-1:CH_SH];
  assign w_ridx = bus.araddr[CH_SH-1:3];

`ifdef AUTH_KEY_READBACK_EN
  logic [DATA_W-1:0] w_racc [NUM_CH+1];
  assign w_racc[0] = '0;
  assign w_rkey    = w_racc[NUM_CH];
`else
  assign w_rkey = '0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_we;
    assign w_we = w_exec && (w_wch == CW'(c));
`ifdef AUTH_KEY_READBACK_EN
    logic [DATA_W-1:0] w_brd;
    assign w_racc[c+1] = w_racc[c] | ((w_rch == CW'(c)) ? w_brd : '0);
`endif
    auth_key_bank #(
      .DATA_W (DATA_W),
      .POLY_W (POLY_W),
      .TOEP_W (TOEP_W),
      .OTP_W  (OTP_W)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_idx   (w_widx),
      .i_wdata (w_wdata),
      .i_copy  (w_copy),
`ifdef AUTH_KEY_READBACK_EN
      .i_ridx  (w_ridx),
      .o_rdata (w_brd),
`endif
      .o_poly  (poly_key[c*POLY_W +: POLY_W]),
      .o_toep  (toep_key[c*TOEP_W +: TOEP_W]),
      .o_otp   (otp_key[c*OTP_W +: OTP_W])
    );
  end

  always_comb begin
    w_sts            = '0;
    w_sts[STS_PEND]  = r_pend;
    w_sts[STS_BUSY]  = busy;
    w_sts[STS_VALID] = r_valid;
  end

  assign w_rsel_sts  = (w_ridx == STS_IDX) && (w_rch < CW'(NUM_CH));
  assign w_rnext     = (w_rsel_sts ? w_sts : '0) | w_rkey;
  assign bus.arready = ~r_rvalid | bus.rready;
  assign w_ar_hs     = bus.arvalid & bus.arready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rnext;
    end else if (bus.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign bus.rvalid = r_rvalid;
  assign bus.rdata  = r_rdata;

endmodule

// File: tb/tb_auth_key_regfile.sv
// Directed bench for auth_key_regfile: one single-channel and one dual-channel instance.
// Key readback expectations follow AUTH_KEY_READBACK_EN.
`timescale 1ns/1ps
module tb_auth_key_regfile;

`ifdef AUTH_KEY_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic commit, busy, commit2, busy2;
  logic [185:0] poly_key;
  logic [230:0] toep_key;
  logic [39:0]  otp_key;
  logic         key_valid;
  logic [371:0] poly_key2;
  logic [461:0] toep_key2;
  logic [79:0]  otp_key2;
  logic         key_valid2;

  int n_chk  = 0;
  int n_pass = 0;

  auth_key_regfile_if #(.DATA_W(64), .ADDR_W(32)) bus ();
  auth_key_regfile_if #(.DATA_W(64), .ADDR_W(32)) bus2 ();

  auth_key_regfile u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .commit    (commit),
    .busy      (busy),
    .poly_key  (poly_key),
    .toep_key  (toep_key),
    .otp_key   (otp_key),
    .key_valid (key_valid)
  );

  auth_key_regfile #(.NUM_CH(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .commit    (commit2),
    .busy      (busy2),
    .poly_key  (poly_key2),
    .toep_key  (toep_key2),
    .otp_key   (otp_key2),
    .key_valid (key_valid2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.awvalid  = 0; bus.wvalid  = 0; bus.arvalid  = 0;
    bus2.awvalid = 0; bus2.wvalid = 0; bus2.arvalid = 0;
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [63:0] d);
    if (s == 0) begin
      bus.awvalid = 1; bus.awaddr = a; bus.wvalid = 1; bus.wdata = d;
    end else begin
      bus2.awvalid = 1; bus2.awaddr = a; bus2.wvalid = 1; bus2.wdata = d;
    end
    tick();
    idle_bus();
    tick();
  endtask

  task automatic rd(input int s, input logic [31:0] a, output logic [63:0] d);
    logic v;
    if (s == 0) begin bus.arvalid = 1; bus.araddr = a; end
    else begin bus2.arvalid = 1; bus2.araddr = a; end
    tick();
    idle_bus();
    v = (s == 0) ? bus.rvalid : bus2.rvalid;
    for (int i = 0; i < 8 && !v; i++) begin
      tick();
      v = (s == 0) ? bus.rvalid : bus2.rvalid;
    end
    chk("rd_rvalid", 256'(v), 256'(1));
    d = (s == 0) ? bus.rdata : bus2.rdata;
    if (s == 0) bus.rready = 1; else bus2.rready = 1;
    tick();
    bus.rready = 0; bus2.rready = 0;
  endtask

  task automatic cmt(input int s);
    if (s == 0) commit = 1; else commit2 = 1;
    tick();
    commit = 0; commit2 = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [191:0] p_exp;
    p_exp = {64'h03FF_FFFF_FFFF_FFFF, 64'h5555_6666_7777_8888,
             64'h1111_2222_3333_4444};
    rst = 1; commit = 0; busy = 0; commit2 = 0; busy2 = 0;
    idle_bus();
    bus.awaddr = 0; bus.wdata = 0; bus.araddr = 0; bus.rready = 0;
    bus2.awaddr = 0; bus2.wdata = 0; bus2.araddr = 0; bus2.rready = 0;
    tick(); tick();
    rst = 0;
    tick();

    chk("rst_awready", 256'(bus.awready), 256'(1));
    chk("rst_wready", 256'(bus.wready), 256'(1));
    chk("rst_arready", 256'(bus.arready), 256'(1));
    chk("rst_rvalid", 256'(bus.rvalid), 256'(0));
    chk("rst_rdata", 256'(bus.rdata), 256'(0));
    chk("rst_key_valid", 256'(key_valid), 256'(0));
    chk("rst_poly", 256'(poly_key), 256'(0));
    chk("rst_toep", 256'(toep_key), 256'(0));
    chk("rst_otp", 256'(otp_key), 256'(0));

    wr(0, 32'h00, 64'h1111_2222_3333_4444);
    wr(0, 32'h08, 64'h5555_6666_7777_8888);
    wr(0, 32'h10, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(0, 32'h10, d);
    chk("rb_poly_top", 256'(d), RB ? 256'(64'h03FF_FFFF_FFFF_FFFF) : 256'(0));
    rd(0, 32'h08, d);
    chk("rb_poly_w1", 256'(d), RB ? 256'(64'h5555_6666_7777_8888) : 256'(0));
    chk("poly_pre_commit", 256'(poly_key), 256'(0));

    bus.wvalid = 1; bus.wdata = 64'hDEAD_BEEF_1234_5678;
    tick();
    chk("w_first_wready", 256'(bus.wready), 256'(0));
    chk("w_first_awready", 256'(bus.awready), 256'(1));
    tick(); tick(); tick();
    bus.awvalid = 1; bus.awaddr = 32'h30;
    tick();
    idle_bus();
    chk("clr_wready", 256'(bus.wready), 256'(0));
    chk("clr_awready", 256'(bus.awready), 256'(0));
    tick();
    chk("free_awready", 256'(bus.awready), 256'(1));
    chk("free_wready", 256'(bus.wready), 256'(1));
    rd(0, 32'h30, d);
    chk("rb_toep_top", 256'(d), RB ? 256'(64'h6F_1234_5678) : 256'(0));

    wr(0, 32'h38, 64'h55);
    busy = 1;
    cmt(0);
    tick();
    chk("busy_key_valid", 256'(key_valid), 256'(0));
    chk("busy_otp", 256'(otp_key), 256'(0));
    rd(0, 32'hF8, d);
    chk("sts_pending", 256'(d), 256'(3));
    busy = 0;
    chk("busy_fall_poly", 256'(poly_key), 256'(0));
    tick();
    chk("commit_poly", 256'(poly_key), 256'(p_exp[185:0]));
    chk("commit_toep_top", 256'(toep_key[230:192]), 256'(39'h6F_1234_5678));
    chk("commit_toep_low", 256'(toep_key[191:0]), 256'(0));
    chk("commit_otp", 256'(otp_key), 256'(40'h55));
    chk("commit_key_valid", 256'(key_valid), 256'(1));
    rd(0, 32'hF8, d);
    chk("sts_valid", 256'(d), 256'(4));

    bus.awvalid = 1; bus.awaddr = 32'h38; bus.wvalid = 1;
    bus.wdata = 64'hAA_AAAA_AAAA;
    commit = 1;
    tick();
    idle_bus();
    commit = 0;
    chk("same_cycle_otp", 256'(otp_key), 256'(40'h55));
    tick();
    cmt(0);
    chk("next_commit_otp", 256'(otp_key), 256'(40'hAA_AAAA_AAAA));

    wr(0, 32'hF8, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(0, 32'hF8, d);
    chk("sts_wr_ignored", 256'(d), 256'(4));
    rd(0, 32'h40, d);
    chk("unmapped_rd", 256'(d), 256'(0));
    rd(0, 32'h3F, d);
    chk("low_bits_ign", 256'(d), RB ? 256'(40'hAA_AAAA_AAAA) : 256'(0));

    bus.awvalid = 1; bus.awaddr = 32'h00; bus.wvalid = 1; bus.wdata = 64'h1;
    tick();
    chk("b2b_ready_lo", 256'(bus.awready), 256'(0));
    bus.wdata = 64'h2;
    tick();
    chk("b2b_ready_hi", 256'(bus.awready), 256'(1));
    tick();
    chk("b2b_ready_lo2", 256'(bus.awready), 256'(0));
    idle_bus();
    tick();
    rd(0, 32'h00, d);
    chk("b2b_data", 256'(d), RB ? 256'(2) : 256'(0));

    bus.rready = 1; bus.arvalid = 1; bus.araddr = 32'hF8;
    tick();
    chk("pipe_rvalid", 256'(bus.rvalid), 256'(1));
    chk("pipe_rdata0", 256'(bus.rdata), 256'(4));
    chk("pipe_arready", 256'(bus.arready), 256'(1));
    bus.araddr = 32'h40;
    tick();
    chk("pipe_rdata1", 256'(bus.rdata), 256'(0));
    bus.arvalid = 0;
    tick();
    chk("pipe_drain", 256'(bus.rvalid), 256'(0));
    bus.rready = 0; bus.arvalid = 1; bus.araddr = 32'hF8;
    tick();
    bus.arvalid = 0; bus.araddr = 32'h40;
    chk("stall_arready", 256'(bus.arready), 256'(0));
    tick();
    chk("stall_rdata", 256'(bus.rdata), 256'(4));
    chk("stall_rvalid", 256'(bus.rvalid), 256'(1));
    bus.rready = 1;
    tick();
    bus.rready = 0;
    chk("stall_release", 256'(bus.rvalid), 256'(0));

    bus.wvalid = 1; bus.wdata = 64'h77;
    tick();
    rst = 1;
    #1;
    chk("arst_awready", 256'(bus.awready), 256'(1));
    chk("arst_wready", 256'(bus.wready), 256'(1));
    idle_bus();
    tick();
    rst = 0;
    tick();
    chk("arst_key_valid", 256'(key_valid), 256'(0));
    bus.awvalid = 1; bus.awaddr = 32'h38;
    tick();
    idle_bus();
    chk("aw_only_held", 256'(bus.awready), 256'(0));
    cmt(0);
    chk("dropped_w_otp", 256'(otp_key), 256'(0));
    bus.wvalid = 1; bus.wdata = 64'h99;
    tick();
    idle_bus();
    tick();
    cmt(0);
    chk("late_w_otp", 256'(otp_key), 256'(40'h99));

    wr(1, 32'h138, 64'h1);
    cmt(1);
    chk("ch1_otp", 256'(otp_key2), 256'(80'h00_0000_0001_00_0000_0000));
    chk("ch1_poly", 256'(poly_key2), 256'(0));
    rd(1, 32'h200, d);
    chk("ch2_oob_rd", 256'(d), 256'(0));
    rd(1, 32'h40, d);
    chk("ch0_unmapped", 256'(d), 256'(0));
    rd(1, 32'h1F8, d);
    chk("ch1_status", 256'(d), 256'(4));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
